pcpi_dispatch: RTL and testbench

//  Sits between the PicoRV32 PCPI port and a bank of N PCPI coprocessors (approx multiplier, others).

---
 rtl/pcpi_pkg.sv | 19 +
 rtl/pcpi_resp_select.sv | 39 +++
 rtl/pcpi_dispatch.sv | 172 +++++++++++++++++
 tb/tb_pcpi_dispatch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI dispatcher: FSM state encoding and the
// custom-instruction encodings the attached coprocessors decode.
package pcpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_CUSTOM0   = 7'b000_1011;
  localparam logic [6:0] FUNCT7_APPROX = 7'b000_0001;

  // True when the word is a CUSTOM0 instruction carrying the approx-multiply funct7
  function automatic logic is_approx_insn(input logic [31:0] insn);
    return (insn[6:0] == OPC_CUSTOM0) && (insn[31:25] == FUNCT7_APPROX);
  endfunction

endpackage

// File: rtl/pcpi_resp_select.sv
// Combinational priority picker over the slave ready strobes. The lowest
// ready index wins; its result and write enable are passed through, and
// the multi flag reports that more than one slave claimed the request.
module pcpi_resp_select #(
  parameter int N_SLAVES = 4
) (
  input  logic [N_SLAVES-1:0]    i_ready,
  input  logic [N_SLAVES-1:0]    i_wr,
  input  logic [32*N_SLAVES-1:0] i_rd,
  output logic                   o_any,
  output logic [31:0]            o_rd,
  output logic                   o_wr,
  output logic                   o_multi
);

  logic w_seen;

  assign o_any = |i_ready;

  // Walk from slave 0 upward: the first ready slave supplies the result, any later one flags a collision
  always_comb begin
    o_rd    = '0;
    o_wr    = 1'b0;
    o_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (i_ready[i]) begin
        if (!w_seen) begin
          o_rd = i_rd[32*i +: 32];
          o_wr = i_wr[i];
        end else begin
          o_multi = 1'b1;
        end
        w_seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: registers one core request, broadcasts it to all
// coprocessor slaves, returns the first claiming slave's result as a
// single registered response, and gives up after a watchdog period in
// which no slave is either ready or asking for more time.
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int TIMEOUT  = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pcpi_valid,
  input  logic [31:0]            pcpi_insn,
  input  logic [31:0]            pcpi_rs1,
  input  logic [31:0]            pcpi_rs2,
  output logic                   pcpi_wr,
  output logic [31:0]            pcpi_rd,
  output logic                   pcpi_wait,
  output logic                   pcpi_ready,
  output logic [N_SLAVES-1:0]    s_pcpi_valid,
  output logic [31:0]            s_pcpi_insn,
  output logic [31:0]            s_pcpi_rs1,
  output logic [31:0]            s_pcpi_rs2,
  input  logic [N_SLAVES-1:0]    s_pcpi_wr,
  input  logic [32*N_SLAVES-1:0] s_pcpi_rd,
  input  logic [N_SLAVES-1:0]    s_pcpi_wait,
  input  logic [N_SLAVES-1:0]    s_pcpi_ready,
  output logic                   err_timeout,
  output logic                   err_multi
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  logic [31:0]        r_insn;
  logic [31:0]        r_rs1;
  logic [31:0]        r_rs2;
  logic [31:0]        r_rd;
  logic               r_wr;
  logic               r_ready;
  logic               r_wait;
  logic               r_err_timeout;
  logic               r_err_multi;

  logic               w_any_ready;
  logic [31:0]        w_sel_rd;
  logic               w_sel_wr;
  logic               w_multi;
  logic               w_any_wait;
  logic               w_respond;
  logic               w_timeout;

  assign w_any_wait = |s_pcpi_wait;

  pcpi_resp_select #(
    .N_SLAVES (N_SLAVES)
  ) u_resp_select (
    .i_ready (s_pcpi_ready),
    .i_wr    (s_pcpi_wr),
    .i_rd    (s_pcpi_rd),
    .o_any   (w_any_ready),
    .o_rd    (w_sel_rd),
    .o_wr    (w_sel_wr),
    .o_multi (w_multi)
  );

  // Next-state and watchdog logic; a core abort beats a slave response, which beats the watchdog
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_respond  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (pcpi_valid) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!pcpi_valid) begin
          w_next     = ST_IDLE;
          w_cnt_next = '0;
        end else if (w_any_ready) begin
          w_respond  = 1'b1;
          w_next     = ST_DONE;
          w_cnt_next = '0;
        end else if (w_any_wait) begin
          w_cnt_next = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_timeout  = 1'b1;
          w_next     = ST_DONE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_cnt_next = '0;
        if (!pcpi_valid) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // State and watchdog counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the core's operands once per request so slaves see a stable copy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_insn <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
    end else if (r_state == ST_IDLE && pcpi_valid) begin
      r_insn <= pcpi_insn;
      r_rs1  <= pcpi_rs1;
      r_rs2  <= pcpi_rs2;
    end
  end

  // Registered response towards the core; strobes last one cycle, the result value is held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd          <= '0;
      r_wr          <= 1'b0;
      r_ready       <= 1'b0;
      r_wait        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_multi   <= 1'b0;
    end else begin
      r_ready       <= w_respond;
      r_wr          <= w_respond & w_sel_wr;
      r_err_multi   <= w_respond & w_multi;
      r_err_timeout <= w_timeout;
      r_wait        <= (r_state == ST_WAIT) && (w_next == ST_WAIT) && w_any_wait;
      if (w_respond) begin
        r_rd <= w_sel_rd;
      end
    end
  end

  assign s_pcpi_valid = {N_SLAVES{r_state == ST_WAIT}};
  assign s_pcpi_insn  = r_insn;
  assign s_pcpi_rs1   = r_rs1;
  assign s_pcpi_rs2   = r_rs2;
  assign pcpi_rd      = r_rd;
  assign pcpi_wr      = r_wr;
  assign pcpi_ready   = r_ready;
  assign pcpi_wait    = r_wait;
  assign err_timeout  = r_err_timeout;
  assign err_multi    = r_err_multi;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Scoreboard bench for pcpi_dispatch: the driver plays core and slaves,
// predicts each transaction's outcome from the dispatch rules and queues
// it; the monitor pops and compares whenever the DUT responds.
module tb_pcpi_dispatch;
  import pcpi_pkg::*;

  localparam int N  = 4;
  localparam int TO = 12;

  logic            clk;
  logic            resetn;
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [31:0]     pcpi_rs1;
  logic [31:0]     pcpi_rs2;
  logic            pcpi_wr;
  logic [31:0]     pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;
  logic [N-1:0]    s_pcpi_valid;
  logic [31:0]     s_pcpi_insn;
  logic [31:0]     s_pcpi_rs1;
  logic [31:0]     s_pcpi_rs2;
  logic [N-1:0]    s_pcpi_wr;
  logic [32*N-1:0] s_pcpi_rd;
  logic [N-1:0]    s_pcpi_wait;
  logic [N-1:0]    s_pcpi_ready;
  logic            err_timeout;
  logic            err_multi;

  typedef struct {
    bit          isTimeout;
    logic [31:0] rd;
    logic        wr;
    logic        multi;
    int          latency;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   raiseCyc = 0;

  pcpi_dispatch #(
    .N_SLAVES (N),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready),
    .s_pcpi_valid (s_pcpi_valid),
    .s_pcpi_insn  (s_pcpi_insn),
    .s_pcpi_rs1   (s_pcpi_rs1),
    .s_pcpi_rs2   (s_pcpi_rs2),
    .s_pcpi_wr    (s_pcpi_wr),
    .s_pcpi_rd    (s_pcpi_rd),
    .s_pcpi_wait  (s_pcpi_wait),
    .s_pcpi_ready (s_pcpi_ready),
    .err_timeout  (err_timeout),
    .err_multi    (err_multi)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure request-to-response latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every DUT response or error pulse must match the oldest queued prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (resetn && (pcpi_ready || err_timeout || err_multi)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_response: ready=%0b timeout=%0b multi=%0b expected no response",
                 pcpi_ready, err_timeout, err_multi);
      end else begin
        e = expQ.pop_front();
        checkOutput("resp_timeout", 32'(err_timeout), 32'(e.isTimeout));
        checkOutput("resp_ready", 32'(pcpi_ready), 32'(!e.isTimeout));
        checkOutput("resp_wr", 32'(pcpi_wr), e.isTimeout ? 32'd0 : 32'(e.wr));
        checkOutput("resp_multi", 32'(err_multi), 32'(e.multi && !e.isTimeout));
        checkOutput("resp_latency", 32'(cyc - raiseCyc), 32'(e.latency));
        if (!e.isTimeout) checkOutput("resp_rd", pcpi_rd, e.rd);
      end
    end
  end

  // One full transaction: slave 2 waits for w WAIT cycles, slaves in mask go ready in WAIT cycle r
  task automatic applyStimulus(input int w, input int r, input logic [N-1:0] mask,
                               input int holdDone, input logic [31:0] rs1);
    logic [31:0] rds[N];
    logic [N-1:0] wrs;
    logic [31:0] tmp;
    logic [31:0] insn;
    logic [31:0] rs2;
    int lowest;
    int c;
    int guard;
    exp_t e;

    @(negedge clk);
    tmp = $urandom();
    insn = {FUNCT7_APPROX, tmp[24:7], OPC_CUSTOM0};
    rs2 = $urandom();
    for (int i = 0; i < N; i++) begin
      rds[i] = $urandom();
      s_pcpi_rd[32*i +: 32] = rds[i];
    end
    wrs = N'($urandom());
    s_pcpi_wr = wrs;
    lowest = 0;
    for (int i = N - 1; i >= 0; i--) if (mask[i]) lowest = i;

    if (r <= w + TO) begin
      e.isTimeout = 1'b0;
      e.rd = rds[lowest];
      e.wr = wrs[lowest];
      e.multi = ($countones(mask) > 1);
      e.latency = r + 2;
    end else begin
      e.isTimeout = 1'b1;
      e.rd = '0;
      e.wr = 1'b0;
      e.multi = 1'b0;
      e.latency = w + TO + 2;
    end
    expQ.push_back(e);

    pcpi_valid = 1'b1;
    pcpi_insn = insn;
    pcpi_rs1 = rs1;
    pcpi_rs2 = rs2;
    raiseCyc = cyc;

    @(negedge clk);
    checkOutput("bcast_valid", 32'(s_pcpi_valid), 32'({N{1'b1}}));
    checkOutput("bcast_insn", s_pcpi_insn, insn);
    checkOutput("bcast_rs1", s_pcpi_rs1, rs1);
    checkOutput("bcast_rs2", s_pcpi_rs2, rs2);

    c = 0;
    guard = 0;
    while (s_pcpi_valid != '0 && guard < 200) begin
      s_pcpi_ready = (c == r) ? mask : '0;
      s_pcpi_wait = (c < w) ? N'(4'b0100) : '0;
      checkOutput("core_wait", 32'(pcpi_wait), 32'((c >= 1) && (c - 1 < w)));
      c++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_bound: still in WAIT after %0d cycles, required exit by %0d", guard, w + TO + 1);
    end

    repeat (holdDone) begin
      checkOutput("done_svalid", 32'(s_pcpi_valid), 32'd0);
      checkOutput("done_wait", 32'(pcpi_wait), 32'd0);
      @(negedge clk);
    end
    pcpi_valid = 1'b0;
    s_pcpi_ready = '0;
    s_pcpi_wait = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Core abandons the request after k WAIT cycles; no response and no error may follow
  task automatic runAbort(input int k);
    int c;
    pcpi_valid = 1'b1;
    pcpi_insn = $urandom();
    pcpi_rs1 = $urandom();
    pcpi_rs2 = $urandom();
    @(negedge clk);
    c = 0;
    while (c < k && s_pcpi_valid != '0) begin
      c++;
      @(negedge clk);
    end
    checkOutput("abort_in_wait", 32'(s_pcpi_valid), 32'({N{1'b1}}));
    pcpi_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_svalid", 32'(s_pcpi_valid), 32'd0);
    repeat (TO + 4) @(negedge clk);
  endtask

  // Check that every output sits at its reset value
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_svalid"}, 32'(s_pcpi_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(pcpi_ready), 32'd0);
    checkOutput({tag, "_wr"}, 32'(pcpi_wr), 32'd0);
    checkOutput({tag, "_rd"}, pcpi_rd, 32'd0);
    checkOutput({tag, "_wait"}, 32'(pcpi_wait), 32'd0);
    checkOutput({tag, "_insn"}, s_pcpi_insn, 32'd0);
    checkOutput({tag, "_rs1"}, s_pcpi_rs1, 32'd0);
    checkOutput({tag, "_errs"}, 32'({err_timeout, err_multi}), 32'd0);
  endtask

  // Reset asserted mid-WAIT must clear outputs without waiting for a clock edge
  task automatic runReset();
    pcpi_valid = 1'b1;
    pcpi_insn = $urandom();
    pcpi_rs1 = $urandom();
    pcpi_rs2 = $urandom();
    s_pcpi_wait = N'(4'b0001);
    @(negedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkResetState("async_reset");
    pcpi_valid = 1'b0;
    s_pcpi_wait = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Stimulus sequence: directed corner cases followed by randomized transactions
  initial begin
    int w;
    int r;
    logic [N-1:0] mask;

    resetn = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn = '0;
    pcpi_rs1 = '0;
    pcpi_rs2 = '0;
    s_pcpi_wr = '0;
    s_pcpi_rd = '0;
    s_pcpi_wait = '0;
    s_pcpi_ready = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] directed: one-cycle slave, collision, timeout, long wait, abort, reset");
    applyStimulus(0, 1, 4'b0001, 2, 32'h0000_0203);
    applyStimulus(0, 1, 4'b1010, 1, $urandom());
    applyStimulus(0, 99, 4'b0000, 3, $urandom());
    applyStimulus(20, 20, 4'b0100, 1, $urandom());
    runAbort(3);
    runReset();
    applyStimulus(0, 1, 4'b0001, 0, $urandom());

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
      r = int'($urandom_range(0, w + TO + 4));
      mask = N'($urandom_range(1, (1 << N) - 1));
      applyStimulus(w, r, mask, int'($urandom_range(0, 3)), $urandom());
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time so a stuck DUT still produces a summary
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
